// File: rtl/sweep_pkg.sv
// Shared types and default widths for the sweep sequencer and its counter.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } sweep_state_t;

  localparam int SWEEP_WIDTH = 3;
  localparam int SWEEP_CYC_W = 4;

endpackage

// File: rtl/updown_cnt.sv
// Loadable, enable-gated up/down counter; load wins over enable.
module updown_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             down,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= down ? count - WIDTH'(1) : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Ping-pong sweep sequencer lo->hi->lo repeated cfg_cycles times over updown_cnt.
// One count step per unpaused cycle; pause freezes everything, abort returns to IDLE.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH = SWEEP_WIDTH,
  parameter int CYC_W = SWEEP_CYC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [CYC_W-1:0] cfg_cycles,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             down,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cycles_left
);

  sweep_state_t     state, state_nxt;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             cnt_en, cnt_load, cnt_dir;
  logic [WIDTH-1:0] cnt_val;
  logic             accept, reject, cyc_dec, cyc_clr;

  updown_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (cnt_val),
    .down     (cnt_dir),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = cfg_lo;
    cnt_dir   = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    cyc_dec   = 1'b0;
    cyc_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_lo >= cfg_hi || cfg_cycles == '0) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = UP;
          end
        end
      end
      UP: begin
        if (abort) begin
          cyc_clr   = 1'b1;
          state_nxt = IDLE;
        end else if (!pause) begin
          cnt_en = 1'b1;
          // Turnaround at hi steps straight to hi-1 so hi is not repeated.
          if (count == hi_q) begin
            cnt_dir   = 1'b1;
            state_nxt = DOWN;
          end
        end
      end
      DOWN: begin
        if (abort) begin
          cyc_clr   = 1'b1;
          state_nxt = IDLE;
        end else if (!pause) begin
          if (count > lo_q) begin
            cnt_en  = 1'b1;
            cnt_dir = 1'b1;
          end else begin
            cyc_dec = 1'b1;
            if (cycles_left == CYC_W'(1)) begin
              state_nxt = DONE;
            end else begin
              cnt_en    = 1'b1;
              state_nxt = UP;
            end
          end
        end
      end
      DONE: begin
        cyc_clr   = abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q        <= '0;
      hi_q        <= '0;
      cycles_left <= '0;
      err         <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        lo_q        <= cfg_lo;
        hi_q        <= cfg_hi;
        cycles_left <= cfg_cycles;
      end else if (cyc_clr) begin
        cycles_left <= '0;
      end else if (cyc_dec) begin
        cycles_left <= cycles_left - CYC_W'(1);
      end
    end
  end

  assign down = (state == DOWN);
  assign busy = (state == UP) || (state == DOWN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a trajectory-list model.
module tb_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cfg_lo = '0;
  logic [2:0] cfg_hi = '0;
  logic [3:0] cfg_cycles = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] count;
  logic       down, busy, done, err;
  logic [3:0] cycles_left;

  int checks = 0;
  int failures = 0;

  // Model: the whole expected run is precomputed as a list of per-edge positions
  // (count, phase 0=up/1=down/2=done, sweeps left); pause holds the position.
  int tr_cnt[$];
  int tr_ph[$];
  int tr_cl[$];
  bit active = 1'b0;
  int idx = 0;
  int idle_cnt = 0;
  int idle_cl = 0;
  bit exp_err = 1'b0;

  sweep_ctrl #(.WIDTH(3), .CYC_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_lo      (cfg_lo),
    .cfg_hi      (cfg_hi),
    .cfg_cycles  (cfg_cycles),
    .pause       (pause),
    .abort       (abort),
    .count       (count),
    .down        (down),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .cycles_left (cycles_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic build(input int lo, input int hi, input int n);
    int cl;
    tr_cnt.delete(); tr_ph.delete(); tr_cl.delete();
    cl = n;
    tr_cnt.push_back(lo); tr_ph.push_back(0); tr_cl.push_back(n);
    while (cl > 0) begin
      for (int c = lo + 1; c <= hi; c++) begin
        tr_cnt.push_back(c); tr_ph.push_back(0); tr_cl.push_back(cl);
      end
      for (int c = hi - 1; c >= lo; c--) begin
        tr_cnt.push_back(c); tr_ph.push_back(1); tr_cl.push_back(cl);
      end
      cl--;
    end
    tr_cnt.push_back(lo); tr_ph.push_back(2); tr_cl.push_back(0);
  endtask

  task automatic model_edge(input int s, input int lo, input int hi, input int n,
                            input int p, input int a);
    exp_err = 1'b0;
    if (!active) begin
      if (s != 0) begin
        if (lo >= hi || n == 0) begin
          exp_err = 1'b1;
        end else begin
          build(lo, hi, n);
          idx = 0;
          active = 1'b1;
        end
      end
    end else if (tr_ph[idx] == 2 || a != 0) begin
      idle_cnt = tr_cnt[idx];
      idle_cl = 0;
      active = 1'b0;
    end else if (p == 0) begin
      idx++;
    end
  endtask

  task automatic check_all();
    int e_cnt, e_cl, e_ph;
    e_cnt = active ? tr_cnt[idx] : idle_cnt;
    e_cl  = active ? tr_cl[idx] : idle_cl;
    e_ph  = active ? tr_ph[idx] : 3;
    chk("count", int'(count), e_cnt);
    chk("cycles_left", int'(cycles_left), e_cl);
    chk("busy", int'(busy), int'(e_ph == 0 || e_ph == 1));
    chk("down", int'(down), int'(e_ph == 1));
    chk("done", int'(done), int'(e_ph == 2));
    chk("err", int'(err), int'(exp_err));
  endtask

  // Called at a falling edge: drive, take one rising edge, check on the next falling edge.
  task automatic step(input int s, input int lo, input int hi, input int n,
                      input int p, input int a);
    start = (s != 0);
    cfg_lo = 3'(lo);
    cfg_hi = 3'(hi);
    cfg_cycles = 4'(n);
    pause = (p != 0);
    abort = (a != 0);
    @(posedge clk);
    model_edge(s, lo, hi, n, p, a);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int lat;
    // Power-on reset
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;

    // Single full sweep 0..7..0
    step(1, 0, 7, 1, 0, 0);
    idle_steps(17);

    // Three short sweeps, with a conflicting start mid-run
    step(1, 2, 4, 3, 0, 0);
    idle_steps(3);
    step(1, 0, 7, 5, 0, 0);
    idle_steps(12);

    // Rejected starts
    step(1, 5, 5, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0);
    step(1, 6, 2, 1, 0, 0);
    idle_steps(2);

    // Pause for 3 cycles at count=5 in UP: done comes 3 cycles late
    step(1, 0, 7, 1, 0, 0);
    idle_steps(5);
    chk("pause_at", int'(count), 5);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      step(0, 0, 0, 0, 0, 0);
      lat++;
    end
    chk("pause_done_lat", lat, 10);
    idle_steps(2);

    // Abort together with pause at count=3 in DOWN
    step(1, 0, 7, 1, 0, 0);
    idle_steps(11);
    chk("abort_at", int'(count), 3);
    step(0, 0, 0, 0, 1, 1);
    chk("abort_cnt", int'(count), 3);
    idle_steps(3);

    // Asynchronous reset mid-UP
    step(1, 0, 7, 1, 0, 0);
    idle_steps(4);
    #2 rst = 1'b0;
    #1;
    active = 1'b0; idle_cnt = 0; idle_cl = 0; exp_err = 1'b0;
    chk("arst_count", int'(count), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cyc", int'(cycles_left), 0);
    @(negedge clk);
    rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int s, lo, hi, n, p, a;
      s  = int'($urandom_range(0, 3) == 0);
      lo = $urandom_range(0, 7);
      hi = $urandom_range(0, 7);
      n  = $urandom_range(0, 4);
      if ($urandom_range(0, 15) == 0) n = $urandom_range(0, 15);
      p  = int'($urandom_range(0, 7) == 0);
      a  = int'($urandom_range(0, 39) == 0);
      step(s, lo, hi, n, p, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Sequencer for the 3-bit up/down counter datapath. On a start request it latches a low bound, a high bound and a sweep count, then drives the counter through repeated ping-pong sweeps lo→hi→lo, owning the `down` direction itself. Sits between a software/testbench command source and the counter. Reports `busy`/`done` and supports pause and abort.

## Interface
- WIDTH, 3, counter and bound width
- CYC_W, 4, width of sweep-count field
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; honoured only in IDLE
- cfg_lo  in  WIDTH  lower bound, sampled with start
- cfg_hi  in  WIDTH  upper bound, sampled with start
- cfg_cycles  in  CYC_W  number of full sweeps, sampled with start
- pause  in  1  level; freezes state and count while high
- abort  in  1  one-cycle; returns to IDLE
- count  out  WIDTH  counter value
- down  out  1  1 while in DOWN state
- busy  out  1  1 in UP or DOWN
- done  out  1  one-cycle pulse at normal completion
- err  out  1  one-cycle pulse on rejected start
- cycles_left  out  CYC_W  remaining sweeps, including the current one

## Operation
- States: IDLE, UP, DOWN, DONE.
- Reset (async, rst=0): state IDLE; count=0, down=0, busy=0, done=0, err=0, cycles_left=0; latched bounds=0.
- IDLE with start=1:
  - If cfg_lo >= cfg_hi or cfg_cycles==0: err=1 next cycle; state stays IDLE; count unchanged.
  - Otherwise: latch cfg_lo, cfg_hi, cfg_cycles; count<=cfg_lo; cycles_left<=cfg_cycles; go to UP.
- UP, per unpaused cycle:
  - count<hi: count<=count+1.
  - count==hi: go to DOWN, count<=hi-1.
- DOWN, per unpaused cycle:
  - count>lo: count<=count-1.
  - count==lo: sweep complete, cycles_left<=cycles_left-1.
    - If cycles_left==1: go to DONE; count holds lo.
    - Else: go to UP, count<=lo+1.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE. count holds lo.
- Arithmetic is unsigned, WIDTH bits. No wrap ever occurs, because lo<hi is enforced.
- Priority, high to low: rst, abort, pause, normal sequencing.
  - abort in UP/DOWN/DONE: next edge goes to IDLE. count holds, cycles_left<=0, no done pulse.
  - abort in IDLE is ignored.
- pause in IDLE or DONE has no effect; DONE still returns to IDLE.
- start outside IDLE is ignored, and the latched configuration is unchanged.
- cfg_* changes after the start cycle have no effect.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Start accepted at edge E0: count=lo, busy=1 after E0.
- One sweep takes 2·(hi−lo) edges to return to lo, plus 1 edge for the turnaround decision at count==lo.
  - For lo=0, hi=7, cycles=1: count=7 after E7, count=0 after E14, state DONE after E15, IDLE after E16.
- Multi-sweep: after the count==lo edge, count=lo+1 on the next edge. lo is not repeated.
- down changes on the same edge as the state change. A paused cycle adds exactly one cycle of latency.
- rst deasserted mid-sweep then reasserted: immediate IDLE; all outputs return to reset values asynchronously.

## Structure
- Package sweep_pkg:
  - typedef enum logic [1:0] sweep_state_t {IDLE, UP, DOWN, DONE}
  - default WIDTH and CYC_W localparams
- Sub-module updown_cnt (clk, rst, en, load, load_val, down, count): a loadable, enable-gated up/down counter, async active-low reset to 0.
- sweep_ctrl holds the FSM, configuration registers and sweep counter, and drives en/load/down into updown_cnt.
- Estimated RTL: about 180 lines.

## Test plan
- Reset mid-UP (lo=0, hi=7, count=4): pull rst low -> count=0, state IDLE, busy=0 immediately, with no clock edge needed.
- start, lo=0, hi=7, cycles=1 -> count 0,1…7,6…0; done pulse after E15; busy low after E15; down=1 only while count goes 6…0.
- start, lo=2, hi=4, cycles=3 -> count sequence 2,3,4,3,2,3,4,3,2,3,4,3,2; cycles_left 3→2→1→0; single done pulse.
- start with lo=5, hi=5 or cycles=0 -> err pulse one cycle later; busy stays 0; count unchanged.
- pause high for 3 cycles at count=5 in UP -> count holds 5 for 3 cycles, then resumes at 6; done delayed by exactly 3 cycles. abort at count=3 in DOWN -> IDLE next edge, count=3, no done.
- start asserted while busy with different cfg -> ignored; original sweep completes unchanged. abort and pause asserted together -> abort wins.
